banked_mem: RTL

//  Parametrised segmented memory: NBANKS word-addressed data banks plus a memory-mapped IO window.

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_bank.sv | 27 ++
 rtl/banked_mem.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state/region types and IO window offsets for banked_mem
package mem_pkg;

  typedef enum logic {MS_INIT, MS_RUN} mem_state_t;

  typedef enum logic [2:0] {
    RG_BANK, RG_IO_STAT, RG_IO_CTRL, RG_PERF_RD, RG_PERF_WR, RG_ERR
  } mem_region_t;

  localparam int IO_STAT    = 0;
  localparam int IO_CTRL    = 1;
  localparam int IO_PERF_RD = 2;
  localparam int IO_PERF_WR = 3;

endpackage

// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - one data bank: byte-enable read/write port plus a read-only port, both registered
module mem_bank #(
  parameter int WIDTH    = 32,
  parameter int BANKSIZE = 512
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [WIDTH/8-1:0]          be,
  input  logic [$clog2(BANKSIZE)-1:0] addr,
  input  logic [WIDTH-1:0]            wd,
  output logic [WIDTH-1:0]            rd,
  input  logic [$clog2(BANKSIZE)-1:0] addr_b,
  output logic [WIDTH-1:0]            rd_b
);

  logic [WIDTH-1:0] mem [BANKSIZE];

  // Port b reads the pre-write word when both ports hit the same address.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH/8; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= wd[8*i +: 8];
    end
    rd   <= mem[addr];
    rd_b <= mem[addr_b];
  end

endmodule

// File: rtl/banked_mem.sv
// rtl/banked_mem.sv - banked data memory with IF port, IO window and zero-init FSM
// Optional read/write access counters at IOBASE+2/+3 when MEM_PERF_CNT_EN is defined.
module banked_mem
  import mem_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter int BANKSIZE         = 512,
  parameter int NBANKS           = 6,
  parameter int IOBASE           = BANKSIZE*(NBANKS+1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        startIO,
  input  logic [WIDTH-1:0]            a1,
  output logic [INSTRUCTIONWIDTH-1:0] rd1,
  input  logic                        dreq,
  input  logic                        we,
  input  logic [WIDTH/8-1:0]          be,
  input  logic [WIDTH-1:0]            a2,
  input  logic [WIDTH-1:0]            wd,
  output logic [WIDTH-1:0]            rd2,
  output logic                        rvalid,
  output logic                        ready,
  output logic                        err
);

  localparam int AW = $clog2(BANKSIZE);
  localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam logic [WIDTH-1:0] BANKWORDS = WIDTH'(NBANKS*BANKSIZE);
  localparam logic [WIDTH-1:0] BSZ       = WIDTH'(BANKSIZE);
  localparam logic [WIDTH-1:0] A_STAT    = WIDTH'(IOBASE + IO_STAT);
  localparam logic [WIDTH-1:0] A_CTRL    = WIDTH'(IOBASE + IO_CTRL);

  mem_state_t       state;
  mem_region_t      region;
  logic [AW-1:0]    idx;
  logic [BW-1:0]    bsel, rsel;
  logic             s1, s2, s3, flag;
  logic             acc, rd_acc, wr_acc, init_wr, flag_clr, if_ok, rbank;
  logic [WIDTH-1:0] io_next, io_val, rd2_hold, if_word;
  logic [WIDTH-1:0] bank_rd [NBANKS];
  logic             unused_ifhi;

`ifdef MEM_PERF_CNT_EN
  localparam logic [WIDTH-1:0] A_PRD = WIDTH'(IOBASE + IO_PERF_RD);
  localparam logic [WIDTH-1:0] A_PWR = WIDTH'(IOBASE + IO_PERF_WR);
  logic [WIDTH-1:0] perf_rd, perf_wr;
  logic             perf_clr;
`endif

  always_comb begin
    region = RG_ERR;
    if (a2 < BANKWORDS)   region = RG_BANK;
    else if (a2 == A_STAT) region = RG_IO_STAT;
    else if (a2 == A_CTRL) region = RG_IO_CTRL;
`ifdef MEM_PERF_CNT_EN
    else if (a2 == A_PRD)  region = RG_PERF_RD;
    else if (a2 == A_PWR)  region = RG_PERF_WR;
`endif
  end

  assign bsel     = a2[AW +: BW];
  assign acc      = dreq && ready && !rst;
  assign rd_acc   = acc && !we && (region == RG_BANK);
  assign wr_acc   = acc && we && (region == RG_BANK);
  assign init_wr  = (state == MS_INIT) && !rst;
  assign flag_clr = acc && we && (region == RG_IO_CTRL) && wd[0];
`ifdef MEM_PERF_CNT_EN
  assign perf_clr = acc && we && (region == RG_IO_CTRL) && wd[1];
`endif

  always_comb begin
    io_next = '0;
    case (region)
      RG_IO_STAT: io_next = {{(WIDTH-1){1'b0}}, flag};
`ifdef MEM_PERF_CNT_EN
      RG_PERF_RD: io_next = perf_rd;
      RG_PERF_WR: io_next = perf_wr;
`endif
      default:    io_next = '0;
    endcase
  end

  for (genvar g = 0; g < NBANKS; g++) begin : g_bank
    logic [WIDTH-1:0] rdb;
    mem_bank #(.WIDTH(WIDTH), .BANKSIZE(BANKSIZE)) u_bank (
      .clk    (clk),
      .we     (init_wr || (wr_acc && (bsel == BW'(g)))),
      .be     (init_wr ? {(WIDTH/8){1'b1}} : be),
      .addr   (init_wr ? idx : a2[AW-1:0]),
      .wd     (init_wr ? {WIDTH{1'b0}} : wd),
      .rd     (bank_rd[g]),
      .addr_b (a1[AW-1:0]),
      .rd_b   (rdb)
    );
    if (g == 0) begin : g_if
      assign if_word = rdb;
    end else begin : g_nc
      logic unused_rdb;
      assign unused_rdb = ^rdb;
    end
  end

  assign unused_ifhi = ^if_word[WIDTH-1:INSTRUCTIONWIDTH];
  assign rd1 = if_ok ? if_word[INSTRUCTIONWIDTH-1:0] : '0;
  // rd2 shows the fresh bank/IO word in the rvalid cycle, then the latched copy.
  assign rd2 = rvalid ? (rbank ? bank_rd[rsel] : io_val) : rd2_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MS_INIT;
      idx      <= '0;
      ready    <= 1'b0;
      rvalid   <= 1'b0;
      err      <= 1'b0;
      rbank    <= 1'b0;
      rsel     <= '0;
      io_val   <= '0;
      rd2_hold <= '0;
      if_ok    <= 1'b0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      flag     <= 1'b0;
`ifdef MEM_PERF_CNT_EN
      perf_rd  <= '0;
      perf_wr  <= '0;
`endif
    end else begin
      s1 <= startIO;
      s2 <= s1;
      s3 <= s2;
      if (s2 && !s3)     flag <= 1'b1;
      else if (flag_clr) flag <= 1'b0;

      if (state == MS_INIT) begin
        idx <= idx + AW'(1);
        if (idx == AW'(BANKSIZE-1)) begin
          state <= MS_RUN;
          ready <= 1'b1;
        end
      end

      if_ok  <= (state == MS_RUN) && (a1 < BSZ);
      if (rvalid) rd2_hold <= rd2;
      rvalid <= acc && !we && (region != RG_ERR);
      err    <= acc && (region == RG_ERR);
      rbank  <= (region == RG_BANK);
      rsel   <= bsel;
      io_val <= io_next;
`ifdef MEM_PERF_CNT_EN
      if (perf_clr) begin
        perf_rd <= '0;
        perf_wr <= '0;
      end else begin
        if (rd_acc) perf_rd <= perf_rd + WIDTH'(1);
        if (wr_acc) perf_wr <= perf_wr + WIDTH'(1);
      end
`endif
    end
  end

`ifndef MEM_PERF_CNT_EN
  logic unused_rdacc;
  assign unused_rdacc = rd_acc;
`endif

endmodule
